// File: rtl/ibus_fetch_sched_pkg.sv
// Shared types for the fetch-stage ibus scheduler: FSM state encoding and the in-flight queue entry.
package ibus_fetch_sched_pkg;

    localparam int MAX_OUTST_DEF = 4;
    localparam int PC_W          = 32;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        KILL
    } sched_state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            stale;
    } sched_entry_t;

endpackage

// File: rtl/ibus_sched_fifo.sv
// Ring buffer of in-flight ibus requests, oldest at the head; flush marks every stored entry stale.
module ibus_sched_fifo
    import ibus_fetch_sched_pkg::*;
#(
    parameter int DEPTH = MAX_OUTST_DEF,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  sched_entry_t       push_entry,
    input  logic               pop,
    input  logic               mark_all_stale,
    output sched_entry_t       head,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sched_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty  = (count == '0);
    assign do_pop = pop & ~empty;
    assign head   = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; occupancy lives in the pointers, so old contents are never observed.
    always_ff @(posedge clk) begin
        if (mark_all_stale) begin
            for (int i = 0; i < DEPTH; i++) mem[i].stale <= 1'b1;
        end
        // A push in the same cycle overrides the blanket stale mark with its own stale bit.
        if (push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/ibus_fetch_sched.sv
// Fetch-side ibus sequencer: issues fetch addresses, queues in-flight requests, kills responses on flush.
// Optional perf counters built only when IBUS_SCHED_PERF_EN is defined.
module ibus_fetch_sched
    import ibus_fetch_sched_pkg::*;
#(
    parameter int MAX_OUTST = MAX_OUTST_DEF,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_accept,
    input  logic              flush,
    output logic              ibus_req,
    output logic [ADDR_W-1:0] ibus_addr,
    input  logic              ibus_addr_ok,
    input  logic              ibus_data_ok,
    input  logic [DATA_W-1:0] ibus_data,
    input  logic              ibus_index,
    output logic              r_valid,
    output logic [DATA_W-1:0] r_data,
    output logic [ADDR_W-1:0] r_pc,
    output logic              r_index,
    output logic [CNT_W-1:0]  outst,
    output logic              busy,
    output logic [31:0]       perf_killed,
    output logic [31:0]       perf_full
);

    sched_state_t      state;
    logic [ADDR_W-1:0] hold_addr;
    sched_entry_t      head;
    sched_entry_t      push_entry;
    logic              empty;
    logic              push;
    logic              pop;
    logic              full;
    int                occ;

    ibus_sched_fifo #(
        .DEPTH (MAX_OUTST),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk            (clk),
        .reset          (reset),
        .push           (push),
        .push_entry     (push_entry),
        .pop            (pop),
        .mark_all_stale (flush),
        .head           (head),
        .empty          (empty),
        .count          (outst)
    );

    assign pop     = reset & ibus_data_ok & ~empty;
    assign r_valid = pop & ~head.stale & ~flush;
    assign r_pc    = ADDR_W'(head.pc);
    assign r_data  = ibus_data;
    assign r_index = ibus_index;
    assign busy    = (outst != '0) || (state != IDLE);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        ibus_req   = 1'b0;
        ibus_addr  = '0;
        f_accept   = 1'b0;
        push       = 1'b0;
        push_entry = '0;
        // A same-cycle pop frees a slot; a pending HOLD/KILL already owns one.
        occ  = int'(outst) + ((state != IDLE) ? 1 : 0) - (pop ? 1 : 0);
        full = (occ >= MAX_OUTST);
        case (state)
            IDLE: begin
                ibus_req   = reset & f_req & ~full & ~flush;
                ibus_addr  = f_addr;
                f_accept   = ibus_req;
                push       = ibus_req & ibus_addr_ok;
                push_entry = '{pc: PC_W'(f_addr), stale: 1'b0};
            end
            HOLD: begin
                ibus_req   = reset;
                ibus_addr  = hold_addr;
                push       = reset & ibus_addr_ok;
                push_entry = '{pc: PC_W'(hold_addr), stale: flush};
            end
            KILL: begin
                ibus_req   = reset;
                ibus_addr  = hold_addr;
                push       = reset & ibus_addr_ok;
                push_entry = '{pc: PC_W'(hold_addr), stale: 1'b1};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            hold_addr <= '0;
        end else begin
            case (state)
                IDLE: if (ibus_req && !ibus_addr_ok) begin
                    hold_addr <= f_addr;
                    state     <= HOLD;
                end
                HOLD: if (ibus_addr_ok)  state <= IDLE;
                      else if (flush)    state <= KILL;
                KILL: if (ibus_addr_ok)  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IBUS_SCHED_PERF_EN
    logic [31:0] killed_q;
    logic [31:0] full_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            killed_q <= '0;
            full_q   <= '0;
        end else begin
            if (pop && !r_valid && killed_q != '1) killed_q <= killed_q + 32'd1;
            if (state == IDLE && f_req && full && full_q != '1) full_q <= full_q + 32'd1;
        end
    end

    assign perf_killed = killed_q;
    assign perf_full   = full_q;
`else
    assign perf_killed = '0;
    assign perf_full   = '0;
`endif

endmodule

// File: tb/tb_ibus_fetch_sched.sv
// Directed bench for ibus_fetch_sched (MAX_OUTST=4); perf expectations follow IBUS_SCHED_PERF_EN.
module tb_ibus_fetch_sched;

    logic        clk;
    logic        reset;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_accept;
    logic        flush;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_addr_ok;
    logic        ibus_data_ok;
    logic [63:0] ibus_data;
    logic        ibus_index;
    logic        r_valid;
    logic [63:0] r_data;
    logic [31:0] r_pc;
    logic        r_index;
    logic [2:0]  outst;
    logic        busy;
    logic [31:0] perf_killed;
    logic [31:0] perf_full;

    int n_cmp = 0;
    int n_err = 0;

    ibus_fetch_sched #(.MAX_OUTST(4), .ADDR_W(32), .DATA_W(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .f_req        (f_req),
        .f_addr       (f_addr),
        .f_accept     (f_accept),
        .flush        (flush),
        .ibus_req     (ibus_req),
        .ibus_addr    (ibus_addr),
        .ibus_addr_ok (ibus_addr_ok),
        .ibus_data_ok (ibus_data_ok),
        .ibus_data    (ibus_data),
        .ibus_index   (ibus_index),
        .r_valid      (r_valid),
        .r_data       (r_data),
        .r_pc         (r_pc),
        .r_index      (r_index),
        .outst        (outst),
        .busy         (busy),
        .perf_killed  (perf_killed),
        .perf_full    (perf_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        f_req = 1'b0; f_addr = '0; flush = 1'b0;
        ibus_addr_ok = 1'b0; ibus_data_ok = 1'b0; ibus_data = '0; ibus_index = 1'b0;
    endtask

    // One fetch accepted by the bus in the same cycle.
    task automatic issue(input logic [31:0] a);
        quiet(); f_req = 1'b1; f_addr = a; ibus_addr_ok = 1'b1;
        #1;
        check("issue_req", 64'(ibus_req), 64'h1);
        check("issue_addr", 64'(ibus_addr), 64'(a));
        tick();
    endtask

    // One response whose delivery state and pc are known in advance.
    task automatic respond(input string tag, input logic exp_valid, input logic [31:0] exp_pc);
        quiet(); ibus_data_ok = 1'b1; ibus_data = {exp_pc, ~exp_pc}; ibus_index = exp_pc[3];
        #1;
        check({tag, "_valid"}, 64'(r_valid), 64'(exp_valid));
        if (exp_valid) begin
            check({tag, "_pc"}, 64'(r_pc), 64'(exp_pc));
            check({tag, "_data"}, r_data, {exp_pc, ~exp_pc});
            check({tag, "_index"}, 64'(r_index), 64'(exp_pc[3]));
        end
        tick();
    endtask

    initial begin
        reset = 1'b0;
        quiet();
        f_req = 1'b1; f_addr = 32'h1234_0000;
        #1;
        check("rst_req_gated", 64'(ibus_req), 64'h0);
        check("rst_accept_gated", 64'(f_accept), 64'h0);
        tick(); tick();
        quiet();
        #1;
        check("rst_outst", 64'(outst), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_rvalid", 64'(r_valid), 64'h0);
        check("rst_perf_killed", 64'(perf_killed), 64'h0);
        check("rst_perf_full", 64'(perf_full), 64'h0);
        reset = 1'b1;
        tick();

        // 1) three back-to-back fetches, then in-order responses
        issue(32'hBFC0_0000);
        check("t1_outst1", 64'(outst), 64'h1);
        issue(32'hBFC0_0008);
        issue(32'hBFC0_0010);
        check("t1_outst3", 64'(outst), 64'h3);
        respond("t1_r0", 1'b1, 32'hBFC0_0000);
        check("t1_outst2", 64'(outst), 64'h2);
        respond("t1_r1", 1'b1, 32'hBFC0_0008);
        respond("t1_r2", 1'b1, 32'hBFC0_0010);
        check("t1_outst0", 64'(outst), 64'h0);
        check("t1_busy0", 64'(busy), 64'h0);

        // 2) addr_ok withheld for two cycles; address held, accept only on the first
        quiet(); f_req = 1'b1; f_addr = 32'hA000_0100;
        #1;
        check("t2_req0", 64'(ibus_req), 64'h1);
        check("t2_accept0", 64'(f_accept), 64'h1);
        tick();
        check("t2_busy_hold", 64'(busy), 64'h1);
        check("t2_outst_hold", 64'(outst), 64'h0);
        quiet(); f_req = 1'b1; f_addr = 32'hDEAD_BEEF;
        #1;
        check("t2_req1", 64'(ibus_req), 64'h1);
        check("t2_addr1", 64'(ibus_addr), 64'hA000_0100);
        check("t2_accept1", 64'(f_accept), 64'h0);
        tick();
        quiet(); f_addr = 32'h5555_0000; ibus_addr_ok = 1'b1;
        #1;
        check("t2_addr2", 64'(ibus_addr), 64'hA000_0100);
        check("t2_accept2", 64'(f_accept), 64'h0);
        tick();
        check("t2_outst_push", 64'(outst), 64'h1);
        respond("t2_r", 1'b1, 32'hA000_0100);

        // 3) flush with two queued and one in HOLD; all three responses dropped
        issue(32'h0000_0100);
        issue(32'h0000_0108);
        quiet(); f_req = 1'b1; f_addr = 32'h0000_0110;
        tick();
        check("t3_outst_pre", 64'(outst), 64'h2);
        quiet(); flush = 1'b1;
        #1;
        check("t3_req_flush", 64'(ibus_req), 64'h1);
        check("t3_accept_flush", 64'(f_accept), 64'h0);
        tick();
        quiet(); ibus_addr_ok = 1'b1;
        #1;
        check("t3_kill_addr", 64'(ibus_addr), 64'h0000_0110);
        tick();
        check("t3_outst3", 64'(outst), 64'h3);
        respond("t3_k0", 1'b0, 32'h0000_0100);
        respond("t3_k1", 1'b0, 32'h0000_0108);
        respond("t3_k2", 1'b0, 32'h0000_0110);
        check("t3_outst0", 64'(outst), 64'h0);
        check("t3_busy0", 64'(busy), 64'h0);
        quiet(); f_req = 1'b1; f_addr = 32'h0000_0180; flush = 1'b1; ibus_addr_ok = 1'b1;
        #1;
        check("t3_idle_flush_req", 64'(ibus_req), 64'h0);
        check("t3_idle_flush_acc", 64'(f_accept), 64'h0);
        tick();
        check("t3_idle_flush_outst", 64'(outst), 64'h0);
        issue(32'h0000_0200);
        respond("t3_live", 1'b1, 32'h0000_0200);
`ifdef IBUS_SCHED_PERF_EN
        check("t3_perf_killed", 64'(perf_killed), 64'h3);
`else
        check("t3_perf_killed", 64'(perf_killed), 64'h0);
`endif

        // 4) full queue blocks, then simultaneous push and pop
        issue(32'h0000_0300);
        issue(32'h0000_0308);
        issue(32'h0000_0310);
        issue(32'h0000_0318);
        check("t4_outst4", 64'(outst), 64'h4);
        quiet(); f_req = 1'b1; f_addr = 32'h0000_0320;
        #1;
        check("t4_full_req", 64'(ibus_req), 64'h0);
        check("t4_full_accept", 64'(f_accept), 64'h0);
        tick();
        check("t4_outst_blocked", 64'(outst), 64'h4);
        quiet(); f_req = 1'b1; f_addr = 32'h0000_0320; ibus_addr_ok = 1'b1;
        ibus_data_ok = 1'b1; ibus_data = 64'hCAFE;
        #1;
        check("t4_pp_req", 64'(ibus_req), 64'h1);
        check("t4_pp_accept", 64'(f_accept), 64'h1);
        check("t4_pp_valid", 64'(r_valid), 64'h1);
        check("t4_pp_pc", 64'(r_pc), 64'h0000_0300);
        tick();
        check("t4_outst_still4", 64'(outst), 64'h4);
        respond("t4_r1", 1'b1, 32'h0000_0308);
        respond("t4_r2", 1'b1, 32'h0000_0310);
        respond("t4_r3", 1'b1, 32'h0000_0318);
        respond("t4_r4", 1'b1, 32'h0000_0320);
        check("t4_outst0", 64'(outst), 64'h0);
`ifdef IBUS_SCHED_PERF_EN
        check("t4_perf_full", 64'(perf_full), 64'h1);
`else
        check("t4_perf_full", 64'(perf_full), 64'h0);
`endif

        // 5) flush with data_ok on a live head; then data_ok on an empty queue
        issue(32'h0000_0400);
        quiet(); flush = 1'b1; ibus_data_ok = 1'b1;
        #1;
        check("t5_flush_rvalid", 64'(r_valid), 64'h0);
        tick();
        check("t5_outst0", 64'(outst), 64'h0);
        quiet(); ibus_data_ok = 1'b1;
        #1;
        check("t5_empty_rvalid", 64'(r_valid), 64'h0);
        tick();
        check("t5_empty_outst", 64'(outst), 64'h0);
        check("t5_empty_busy", 64'(busy), 64'h0);
`ifdef IBUS_SCHED_PERF_EN
        check("t5_perf_killed", 64'(perf_killed), 64'h4);
`else
        check("t5_perf_killed", 64'(perf_killed), 64'h0);
`endif

        // 6) reset while in HOLD with entries queued
        issue(32'h0000_0500);
        issue(32'h0000_0508);
        quiet(); f_req = 1'b1; f_addr = 32'h0000_0510;
        tick();
        check("t6_busy_pre", 64'(busy), 64'h1);
        quiet(); reset = 1'b0;
        tick();
        check("t6_outst", 64'(outst), 64'h0);
        check("t6_busy", 64'(busy), 64'h0);
        check("t6_req", 64'(ibus_req), 64'h0);
        check("t6_addr", 64'(ibus_addr), 64'h0);
        check("t6_accept", 64'(f_accept), 64'h0);
        check("t6_rvalid", 64'(r_valid), 64'h0);
        check("t6_rpc", 64'(r_pc), 64'h0);
        check("t6_perf_killed", 64'(perf_killed), 64'h0);
        check("t6_perf_full", 64'(perf_full), 64'h0);
        reset = 1'b1;
        tick();
        check("t6_idle_req", 64'(ibus_req), 64'h0);
        issue(32'h0000_0600);
        respond("t6_r", 1'b1, 32'h0000_0600);
        check("t6_end_outst", 64'(outst), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
